branch_predictor: RTL and testbench

- Dynamic branch predictor and branch-resolution stage for the RV32I pipeline.
- IF side: a combinational lookup into a direct-mapped BTB with 2-bit saturating counters supplies predicted-taken and target for the fetch PC.
- EX side: drives o_br_un to the branch comparator and takes back its less/equal flags. From these and funct3 it resolves the branch, flags mispredicts, produces the redirect PC, and trains the table on the next clock edge.

---
 rtl/bp_pkg.sv | 30 +++
 rtl/bp_sat_counter.sv | 23 ++
 rtl/branch_predictor.sv | 133 +++++++++++++
 tb/tb_branch_predictor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
//   - funct3 encodings of the RV32I conditional branches
//   - cnt_t       : 2-bit saturating direction counter
//   - CNT_INIT    : counter value after reset (weakly not-taken)
//   - bp_entry_t  : one BTB entry {valid, tag, target, cnt}
package bp_pkg;

  localparam int BP_PC_WIDTH   = 32;
  localparam int BP_INDEX_BITS = 4;
  localparam int BP_TAG_WIDTH  = BP_PC_WIDTH - BP_INDEX_BITS - 2;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_INIT = 2'b01;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_WIDTH-1:0] tag;
    logic [BP_PC_WIDTH-1:0]  target;
    cnt_t                    cnt;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state of a 2-bit saturating direction counter.
// Ports:
//   cnt       current counter value
//   taken     resolved branch direction
//   cnt_next  counter after training (saturates at 2'b11 and 2'b00)
module bp_sat_counter
  import bp_pkg::*;
(
  input  cnt_t cnt,
  input  logic taken,
  output cnt_t cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != 2'b11) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor plus EX-stage branch resolution.
// Ports:
//   i_clk, i_reset            clock, asynchronous active-low reset
//   i_if_pc                   fetch PC to look up
//   o_pred_taken/_target      IF prediction (target is 0 when not taken)
//   i_ex_*                    EX-stage instruction info and carried prediction
//   o_br_un                   unsigned-compare select to the comparator
//   i_br_less, i_br_equal     comparator flags
//   o_ex_taken                resolved direction
//   o_mispredict              flush/redirect request
//   o_redirect_pc             correct next PC
//   o_br_count                resolved branches/jumps (wraps)
//   o_mispred_count           mispredicts (wraps)
module branch_predictor
  import bp_pkg::*;
#(
  parameter int   INDEX_BITS = 4,
  parameter int   PC_WIDTH   = 32,
  parameter cnt_t CNT_INIT   = bp_pkg::CNT_INIT
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [PC_WIDTH-1:0] i_if_pc,
  output logic                o_pred_taken,
  output logic [PC_WIDTH-1:0] o_pred_target,
  input  logic                i_ex_valid,
  input  logic                i_ex_is_branch,
  input  logic                i_ex_is_jump,
  input  logic [2:0]          i_ex_funct3,
  input  logic [PC_WIDTH-1:0] i_ex_pc,
  input  logic [PC_WIDTH-1:0] i_ex_target,
  input  logic                i_ex_pred_taken,
  input  logic [PC_WIDTH-1:0] i_ex_pred_target,
  output logic                o_br_un,
  input  logic                i_br_less,
  input  logic                i_br_equal,
  output logic                o_ex_taken,
  output logic                o_mispredict,
  output logic [PC_WIDTH-1:0] o_redirect_pc,
  output logic [31:0]         o_br_count,
  output logic [31:0]         o_mispred_count
);

  localparam int DEPTH   = 1 << INDEX_BITS;
  localparam int TAG_W   = PC_WIDTH - INDEX_BITS - 2;

  // The entry struct is sized by the package geometry, so the instance
  // parameters have to agree with it.
  if (PC_WIDTH != BP_PC_WIDTH || INDEX_BITS != BP_INDEX_BITS) begin : g_geom_check
    $error("branch_predictor: PC_WIDTH/INDEX_BITS must match bp_pkg geometry");
  end

  bp_entry_t table_q [DEPTH];
  logic [31:0] br_count_q;
  logic [31:0] mispred_count_q;

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]      if_tag, ex_tag;
  bp_entry_t             if_entry, ex_entry;
  logic                  if_hit, ex_hit;
  logic                  ex_active, cond_taken, taken, mispredict;
  cnt_t                  cnt_next;
  logic [1:0]            unused_if_pc_bits;

  assign if_idx   = i_if_pc[INDEX_BITS+1:2];
  assign if_tag   = i_if_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign ex_idx   = i_ex_pc[INDEX_BITS+1:2];
  assign ex_tag   = i_ex_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign unused_if_pc_bits = i_if_pc[1:0];

  // Lookups read the registered table only, so an update landing on the
  // same index this cycle is not visible until the next cycle.
  assign if_entry = table_q[if_idx];
  assign ex_entry = table_q[ex_idx];
  assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);
  assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);

  assign o_pred_taken  = if_hit && if_entry.cnt[1];
  assign o_pred_target = o_pred_taken ? if_entry.target : '0;

  assign o_br_un = i_ex_funct3[1];

  always_comb begin
    cond_taken = 1'b0;
    case (i_ex_funct3)
      F3_BEQ:           cond_taken = i_br_equal;
      F3_BNE:           cond_taken = !i_br_equal;
      F3_BLT, F3_BLTU:  cond_taken = i_br_less;
      F3_BGE, F3_BGEU:  cond_taken = !i_br_less;
      default:          cond_taken = 1'b0;
    endcase
  end

  assign ex_active  = i_ex_valid && (i_ex_is_branch || i_ex_is_jump);
  assign taken      = ex_active && (i_ex_is_jump || cond_taken);
  assign mispredict = ex_active &&
                      ((taken != i_ex_pred_taken) ||
                       (taken && i_ex_pred_taken && (i_ex_target != i_ex_pred_target)));

  assign o_ex_taken      = taken;
  assign o_mispredict    = mispredict;
  assign o_redirect_pc   = !ex_active ? '0 :
                           taken      ? i_ex_target : (i_ex_pc + PC_WIDTH'(4));
  assign o_br_count      = br_count_q;
  assign o_mispred_count = mispred_count_q;

  bp_sat_counter u_sat_counter (
    .cnt      (ex_entry.cnt),
    .taken    (taken),
    .cnt_next (cnt_next)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_INIT};
      end
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else if (ex_active) begin
      br_count_q <= br_count_q + 32'd1;
      if (mispredict) mispred_count_q <= mispred_count_q + 32'd1;
      if (ex_hit) begin
        table_q[ex_idx].cnt <= cnt_next;
        if (taken) table_q[ex_idx].target <= i_ex_target;
      end else if (taken) begin
        // Allocation replaces whatever aliased into this slot.
        table_q[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: i_ex_target, cnt: 2'b10};
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_if_pc;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_ex_valid, i_ex_is_branch, i_ex_is_jump;
  logic [2:0]  i_ex_funct3;
  logic [31:0] i_ex_pc, i_ex_target;
  logic        i_ex_pred_taken;
  logic [31:0] i_ex_pred_target;
  logic        o_br_un;
  logic        i_br_less, i_br_equal;
  logic        o_ex_taken, o_mispredict;
  logic [31:0] o_redirect_pc, o_br_count, o_mispred_count;

  always #5 i_clk = ~i_clk;

  branch_predictor dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_if_pc(i_if_pc),
    .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target),
    .i_ex_valid(i_ex_valid), .i_ex_is_branch(i_ex_is_branch), .i_ex_is_jump(i_ex_is_jump),
    .i_ex_funct3(i_ex_funct3), .i_ex_pc(i_ex_pc), .i_ex_target(i_ex_target),
    .i_ex_pred_taken(i_ex_pred_taken), .i_ex_pred_target(i_ex_pred_target),
    .o_br_un(o_br_un), .i_br_less(i_br_less), .i_br_equal(i_br_equal),
    .o_ex_taken(o_ex_taken), .o_mispredict(o_mispredict), .o_redirect_pc(o_redirect_pc),
    .o_br_count(o_br_count), .o_mispred_count(o_mispred_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: the table as plain arrays, counter as an integer 0..3.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  bit [31:0]   m_target[16];
  int          m_cnt   [16];
  bit [31:0]   m_br_count, m_mispred_count;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_cnt[i] = 1;
    end
    m_br_count = 0; m_mispred_count = 0;
  endfunction

  function automatic bit model_hit(input bit [31:0] pc);
    int unsigned idx = (pc >> 2) % 16;
    return m_valid[idx] && (m_tag[idx] == (pc >> 6));
  endfunction

  function automatic bit cond_of(input bit [2:0] f3, input bit less, input bit eq);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4, 3'd6: return less;
      3'd5, 3'd7: return !less;
      default: return 0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] if_pc;
    logic        valid, is_branch, is_jump;
    logic [2:0]  f3;
    logic [31:0] pc, tgt;
    logic        ptaken;
    logic [31:0] ptgt;
    logic        less, equal;
  } stim_t;

  function automatic stim_t mk(input logic [31:0] if_pc, input logic valid, input logic isb,
                               input logic isj, input logic [2:0] f3, input logic [31:0] pc,
                               input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt,
                               input logic less, input logic equal);
    stim_t s;
    s.if_pc = if_pc; s.valid = valid; s.is_branch = isb; s.is_jump = isj; s.f3 = f3;
    s.pc = pc; s.tgt = tgt; s.ptaken = ptaken; s.ptgt = ptgt; s.less = less; s.equal = equal;
    return s;
  endfunction

  logic        cap_pt, cap_taken, cap_misp, cap_br_un;
  logic [31:0] cap_ptgt, cap_redir;

  task automatic apply(input stim_t s);
    i_if_pc = s.if_pc; i_ex_valid = s.valid; i_ex_is_branch = s.is_branch;
    i_ex_is_jump = s.is_jump; i_ex_funct3 = s.f3; i_ex_pc = s.pc; i_ex_target = s.tgt;
    i_ex_pred_taken = s.ptaken; i_ex_pred_target = s.ptgt;
    i_br_less = s.less; i_br_equal = s.equal;
  endtask

  // One pipeline cycle: drive at negedge, check against the model, train on posedge.
  task automatic step(input stim_t s);
    int unsigned ii, ie;
    bit e_pt, act, tk, misp, hit;
    bit [31:0] e_ptgt, redir;
    @(negedge i_clk);
    apply(s);
    #1;
    ii   = (s.if_pc >> 2) % 16;
    e_pt = model_hit(s.if_pc) && (m_cnt[ii] >= 2);
    e_ptgt = e_pt ? m_target[ii] : 32'h0;
    act  = s.valid && (s.is_branch || s.is_jump);
    tk   = act && (s.is_jump || cond_of(s.f3, s.less, s.equal));
    misp = act && ((tk != s.ptaken) || (tk && s.ptaken && s.tgt != s.ptgt));
    redir = !act ? 32'h0 : (tk ? s.tgt : s.pc + 32'd4);
    cap_pt = o_pred_taken; cap_ptgt = o_pred_target; cap_taken = o_ex_taken;
    cap_misp = o_mispredict; cap_redir = o_redirect_pc; cap_br_un = o_br_un;
    chk("pred_taken",    {31'b0, o_pred_taken}, {31'b0, e_pt});
    chk("pred_target",   o_pred_target, e_ptgt);
    chk("ex_taken",      {31'b0, o_ex_taken}, {31'b0, tk});
    chk("mispredict",    {31'b0, o_mispredict}, {31'b0, misp});
    chk("redirect_pc",   o_redirect_pc, redir);
    chk("br_un",         {31'b0, o_br_un}, {31'b0, s.f3[1]});
    chk("br_count",      o_br_count, m_br_count);
    chk("mispred_count", o_mispred_count, m_mispred_count);
    @(posedge i_clk);
    if (act) begin
      ie  = (s.pc >> 2) % 16;
      hit = model_hit(s.pc);
      m_br_count++;
      if (misp) m_mispred_count++;
      if (hit && tk) begin
        m_cnt[ie] = (m_cnt[ie] < 3) ? m_cnt[ie] + 1 : 3;
        m_target[ie] = s.tgt;
      end else if (hit) begin
        m_cnt[ie] = (m_cnt[ie] > 0) ? m_cnt[ie] - 1 : 0;
      end else if (tk) begin
        m_valid[ie] = 1; m_tag[ie] = s.pc >> 6; m_target[ie] = s.tgt; m_cnt[ie] = 2;
      end
    end
  endtask

  stim_t idle;

  typedef struct {
    logic [2:0] f3;
    logic less, equal, is_branch, is_jump, valid;
    logic exp_taken;
  } vec_t;

  vec_t vecs[15];

  initial begin
    idle = mk(32'h0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 0, 0);
    // f3, less, equal, branch, jump, valid, expected taken
    vecs[0]  = '{3'b000, 0, 1, 1, 0, 1, 1};
    vecs[1]  = '{3'b000, 1, 0, 1, 0, 1, 0};
    vecs[2]  = '{3'b001, 0, 0, 1, 0, 1, 1};
    vecs[3]  = '{3'b001, 0, 1, 1, 0, 1, 0};
    vecs[4]  = '{3'b100, 1, 0, 1, 0, 1, 1};
    vecs[5]  = '{3'b100, 0, 1, 1, 0, 1, 0};
    vecs[6]  = '{3'b110, 0, 0, 1, 0, 1, 0};  // 0xFFFFFFFF <u 1 is false
    vecs[7]  = '{3'b110, 1, 0, 1, 0, 1, 1};
    vecs[8]  = '{3'b101, 0, 0, 1, 0, 1, 1};
    vecs[9]  = '{3'b111, 1, 0, 1, 0, 1, 0};
    vecs[10] = '{3'b010, 1, 1, 1, 0, 1, 0};
    vecs[11] = '{3'b011, 0, 0, 1, 0, 1, 0};
    vecs[12] = '{3'b001, 0, 1, 1, 1, 1, 1};  // jump wins over branch
    vecs[13] = '{3'b000, 0, 1, 1, 0, 0, 0};  // bubble
    vecs[14] = '{3'b000, 0, 1, 0, 0, 1, 0};  // not a control-flow op

    apply(idle);
    i_reset = 1'b0;
    model_reset();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;

    // Reset state.
    step(mk(32'h100, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 0, 0));
    chk("reset_pred_taken", {31'b0, cap_pt}, 32'd0);
    chk("reset_redirect", cap_redir, 32'h0);

    // BEQ at 0x100 taken, predicted not-taken.
    step(mk(32'h0, 1, 1, 0, 3'b000, 32'h100, 32'h140, 0, 32'h0, 0, 1));
    chk("beq_mispredict", {31'b0, cap_misp}, 32'd1);
    chk("beq_redirect", cap_redir, 32'h140);
    step(mk(32'h100, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 0, 0));
    chk("alloc_pred_taken", {31'b0, cap_pt}, 32'd1);
    chk("alloc_pred_target", cap_ptgt, 32'h140);

    // Three not-taken resolutions: 10 -> 01 -> 00 -> 00.
    for (int k = 0; k < 3; k++) begin
      step(mk(32'h100, 1, 1, 0, 3'b000, 32'h100, 32'h140, 0, 32'h0, 0, 0));
      chk("nt_redirect", cap_redir, 32'h104);
    end
    step(mk(32'h100, 1, 1, 0, 3'b000, 32'h100, 32'h140, 0, 32'h0, 0, 1));
    chk("sat_floor_pred", {31'b0, cap_pt}, 32'd0);
    step(mk(32'h100, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 0, 0));
    chk("after_floor_pred", {31'b0, cap_pt}, 32'd0);

    // Predicted taken to the wrong target.
    step(mk(32'h0, 1, 0, 1, 3'd0, 32'h300, 32'h500, 1, 32'h504, 0, 0));
    chk("target_mispredict", {31'b0, cap_misp}, 32'd1);

    // Direction decode table.
    for (int i = 0; i < 15; i++) begin
      step(mk(32'h0, vecs[i].valid, vecs[i].is_branch, vecs[i].is_jump, vecs[i].f3,
              32'h800 + 32'(i) * 32'h40, 32'h900, 0, 32'h0, vecs[i].less, vecs[i].equal));
      chk("vec_taken", {31'b0, cap_taken}, {31'b0, vecs[i].exp_taken});
      chk("vec_br_un", {31'b0, cap_br_un}, {31'b0, vecs[i].f3[1]});
    end

    // Aliasing: 0x140 shares index 0 with 0x100.
    step(mk(32'h0, 1, 0, 1, 3'd0, 32'h100, 32'h200, 0, 32'h0, 0, 0));
    step(mk(32'h0, 1, 1, 0, 3'b000, 32'h140, 32'h180, 0, 32'h0, 0, 1));
    step(mk(32'h100, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 0, 0));
    chk("alias_evicted", {31'b0, cap_pt}, 32'd0);
    step(mk(32'h140, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 0, 0));
    chk("alias_new", cap_ptgt, 32'h180);

    // Same-cycle lookup and update of 0x140: lookup sees the old target.
    step(mk(32'h140, 1, 0, 1, 3'd0, 32'h140, 32'h1C0, 1, 32'h180, 0, 0));
    chk("no_bypass", cap_ptgt, 32'h180);
    step(mk(32'h140, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 0, 0));
    chk("post_update", cap_ptgt, 32'h1C0);

    // PC+4 truncation at the top of the address space.
    step(mk(32'h0, 1, 1, 0, 3'b001, 32'hFFFF_FFFC, 32'h40, 0, 32'h0, 0, 1));
    chk("redirect_wrap", cap_redir, 32'h0);

    // Counter wrap via backdoor preload.
    step(idle);
    @(negedge i_clk);
    force dut.br_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_count_q;
    m_br_count = 32'hFFFF_FFFF;
    step(mk(32'h0, 1, 0, 1, 3'd0, 32'h600, 32'h700, 1, 32'h700, 0, 0));
    step(idle);
    chk("br_count_wrap", o_br_count, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      stim_t s;
      logic [31:0] pc;
      pc = (n % 37 == 0) ? 32'hFFFF_FFFC : 32'h1000 + ($urandom_range(0, 31) << 2);
      s = mk(32'h1000 + ($urandom_range(0, 31) << 2), ($urandom_range(0, 7) != 0),
             $urandom_range(0, 1), ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
             pc, 32'h2000 + ($urandom_range(0, 7) << 2), 0, 32'h0,
             $urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        s.ptaken = model_hit(pc) && (m_cnt[(pc >> 2) % 16] >= 2);
        s.ptgt   = s.ptaken ? m_target[(pc >> 2) % 16] : 32'h0;
      end else begin
        s.ptaken = $urandom_range(0, 1);
        s.ptgt   = 32'h2000 + ($urandom_range(0, 7) << 2);
      end
      step(s);
    end

    // Reset asserted while an update is pending.
    step(mk(32'h0, 1, 0, 1, 3'd0, 32'h100, 32'h240, 0, 32'h0, 0, 0));
    @(negedge i_clk);
    apply(mk(32'h100, 1, 0, 1, 3'd0, 32'h100, 32'h280, 1, 32'h240, 0, 0));
    #1;
    chk("pre_reset_pred", {31'b0, o_pred_taken}, 32'd1);
    #2;
    i_reset = 1'b0;
    #1;
    chk("mid_reset_pred", {31'b0, o_pred_taken}, 32'd0);
    chk("mid_reset_count", o_br_count, 32'h0);
    @(posedge i_clk);
    @(negedge i_clk);
    apply(idle);
    i_reset = 1'b1;
    model_reset();
    step(mk(32'h100, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 0, 0));
    chk("post_reset_pred", {31'b0, cap_pt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
